// File: rtl/rr_arb_mux_pkg.sv
// Shared arbiter core types: grant-index type and select-width helper.
`default_nettype none

package rr_arb_mux_pkg;

   localparam int MAX_INS = 16;
   localparam int IDX_W   = $clog2(MAX_INS);

   typedef logic [IDX_W-1:0] grant_idx_t;

   // Select width for an n-channel arbiter; never narrower than one bit.
   function automatic int sel_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb_mux_prio_enc.sv
// Round-robin search: first request at or after ptr_i, wrapping N-1 -> 0.
`default_nettype none

module rr_prio_enc
   import rr_arb_mux_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] req_i,
   input  grant_idx_t   ptr_i,
   output logic [N-1:0] gnt_o,
   output grant_idx_t   idx_o,
   output logic         any_o
);

   int c;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      c     = 0;
      for (int k = 0; k < N; k++) begin
         // ptr_i < N always holds, so one conditional subtract wraps the index.
         c = int'(ptr_i) + k;
         if (c >= N) c = c - N;
         if (!any_o && req_i[c]) begin
            any_o    = 1'b1;
            gnt_o[c] = 1'b1;
            idx_o    = grant_idx_t'(c);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/rr_arb_mux.sv
// N-to-1 round-robin arbitrating multiplexer with a single registered output stage.
`default_nettype none

module rr_arb_mux
   import rr_arb_mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N_INS = 8,
   localparam int SEL_W = sel_width(N_INS)
) (
   input  logic                        clk,
   input  logic                        rst_aL,
   input  logic [N_INS-1:0][WIDTH-1:0] ins,
   input  logic [N_INS-1:0]            ins_valid,
   output logic [N_INS-1:0]            ins_ready,
   output logic [WIDTH-1:0]            out,
   output logic [SEL_W-1:0]            out_sel,
   output logic                        out_valid,
   input  logic                        out_ready
);

   grant_idx_t       ptr_q, ptr_d;
   grant_idx_t       gnt_idx;
   logic [N_INS-1:0] gnt;
   logic             any_req;
   logic             can_load;
   logic             xfer;
   logic [WIDTH-1:0] mux_data;
   logic [WIDTH-1:0] out_q, out_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             vld_q, vld_d;

   rr_prio_enc #(
      .N (N_INS)
   ) u_prio_enc (
      .req_i (ins_valid),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (any_req)
   );

   assign can_load  = !vld_q || out_ready;
   assign xfer      = any_req && can_load;
   // Reset gating keeps every ready low while rst_aL is held.
   assign ins_ready = (rst_aL && can_load) ? gnt : '0;

   always_comb begin
      mux_data = '0;
      for (int i = 0; i < N_INS; i++) begin
         mux_data = mux_data | (ins[i] & {WIDTH{gnt[i]}});
      end
   end

   always_comb begin
      out_d = out_q;
      sel_d = sel_q;
      vld_d = vld_q;
      ptr_d = ptr_q;
      if (xfer) begin
         out_d = mux_data;
         sel_d = SEL_W'(gnt_idx);
         vld_d = 1'b1;
         ptr_d = (gnt_idx == grant_idx_t'(N_INS - 1)) ? '0 : gnt_idx + grant_idx_t'(1);
      end else if (out_ready) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         out_q <= '0;
         sel_q <= '0;
         vld_q <= 1'b0;
         ptr_q <= '0;
      end else begin
         out_q <= out_d;
         sel_q <= sel_d;
         vld_q <= vld_d;
         ptr_q <= ptr_d;
      end
   end

   assign out       = out_q;
   assign out_sel   = sel_q;
   assign out_valid = vld_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench for rr_arb_mux: 4-channel and 5-channel instances, reference model predicts grants.
`default_nettype none

module tb_rr_arb_mux;

   logic                  clk = 1'b0;
   logic                  rst_aL;
   logic [15:0][7:0]      ins_all;
   logic [15:0]           valid;
   logic                  out_ready;
   logic                  use5;

   logic [3:0]            rdy4;
   logic [7:0]            out4;
   logic [1:0]            sel4;
   logic                  vld4;
   logic [4:0]            rdy5;
   logic [7:0]            out5;
   logic [2:0]            sel5;
   logic                  vld5;

   logic [15:0]           obs_ready;
   logic [7:0]            obs_out;
   logic [3:0]            obs_sel;
   logic                  obs_vld;

   int                    n_chk  = 0;
   int                    n_pass = 0;
   int                    mptr   = 0;
   logic                  mvld   = 1'b0;
   logic [11:0]           sb[$];

   always #5 clk = ~clk;

   rr_arb_mux #(.WIDTH(8), .N_INS(4)) dut4 (
      .clk       (clk),
      .rst_aL    (rst_aL),
      .ins       (ins_all[3:0]),
      .ins_valid (valid[3:0]),
      .ins_ready (rdy4),
      .out       (out4),
      .out_sel   (sel4),
      .out_valid (vld4),
      .out_ready (out_ready)
   );

   rr_arb_mux #(.WIDTH(8), .N_INS(5)) dut5 (
      .clk       (clk),
      .rst_aL    (rst_aL),
      .ins       (ins_all[4:0]),
      .ins_valid (valid[4:0]),
      .ins_ready (rdy5),
      .out       (out5),
      .out_sel   (sel5),
      .out_valid (vld5),
      .out_ready (out_ready)
   );

   always_comb begin
      if (use5) begin
         obs_ready = 16'(rdy5);
         obs_out   = out5;
         obs_sel   = 4'(sel5);
         obs_vld   = vld5;
      end else begin
         obs_ready = 16'(rdy4);
         obs_out   = out4;
         obs_sel   = 4'(sel4);
         obs_vld   = vld4;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // One clock: predict grant from the model, check DUT, update model, advance.
   task automatic cycle();
      int          n;
      int          g;
      int          c;
      logic        can;
      logic [15:0] exp_rdy;
      logic [11:0] e;
      n       = use5 ? 5 : 4;
      g       = -1;
      exp_rdy = '0;
      #1;
      can = !mvld || out_ready;
      if (can) begin
         for (int k = 0; k < n; k++) begin
            c = (mptr + k) % n;
            if (g < 0 && valid[c]) g = c;
         end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("ins_ready", 32'(obs_ready), 32'(exp_rdy));
      chk("out_valid", 32'(obs_vld), 32'(mvld));
      if (mvld && out_ready) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("out", 32'(obs_out), 32'(e[7:0]));
            chk("out_sel", 32'(obs_sel), 32'(e[11:8]));
         end
      end
      if (g >= 0) begin
         sb.push_back({4'(g), ins_all[g]});
         mptr = (g + 1) % n;
         mvld = 1'b1;
      end else if (out_ready) begin
         mvld = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset applied between edges; effects checked before the next edge.
   task automatic do_reset();
      rst_aL = 1'b0;
      #2;
      chk("rst_out_valid", 32'(obs_vld), 32'd0);
      chk("rst_out_sel", 32'(obs_sel), 32'd0);
      chk("rst_out", 32'(obs_out), 32'd0);
      chk("rst_ins_ready", 32'(obs_ready), 32'd0);
      mptr = 0;
      mvld = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      rst_aL = 1'b1;
   endtask

   task automatic rand_phase(input int cycles, input int n);
      for (int t = 0; t < cycles; t++) begin
         for (int i = 0; i < n; i++) ins_all[i] = 8'($urandom);
         valid     = 16'($urandom) & 16'((1 << n) - 1);
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
   endtask

   initial begin
      rst_aL    = 1'b0;
      ins_all   = '0;
      valid     = 16'hffff;
      out_ready = 1'b0;
      use5      = 1'b0;
      #1;
      do_reset();

      // Full-load rotation across all four channels.
      ins_all[0] = 8'h00; ins_all[1] = 8'h11; ins_all[2] = 8'h22; ins_all[3] = 8'h33;
      valid     = 16'h000f;
      out_ready = 1'b1;
      for (int t = 0; t < 6; t++) cycle();

      // Wrap-around grant: ptr moves to 2, then only 0 and 1 request.
      valid = 16'h0002; cycle();
      valid = 16'h0003; cycle();
      valid = 16'h0000; cycle(); cycle();

      // Back-pressure hold then release.
      valid = 16'h000f; cycle();
      out_ready = 1'b0;
      for (int t = 0; t < 5; t++) begin
         for (int i = 0; i < 4; i++) ins_all[i] = 8'($urandom);
         cycle();
      end
      out_ready = 1'b1;
      cycle(); cycle();

      // Lone requester on the top channel.
      valid = 16'h0008;
      for (int t = 0; t < 6; t++) cycle();

      rand_phase(150, 4);

      // Reset while a beat is held, then idle inputs.
      valid = 16'h000f; out_ready = 1'b0; cycle();
      do_reset();
      valid = 16'h0000; out_ready = 1'b1;
      for (int t = 0; t < 3; t++) cycle();

      // Five-channel instance: requests on 4 and 0 with ptr at 4.
      use5 = 1'b1;
      do_reset();
      for (int i = 0; i < 5; i++) ins_all[i] = 8'(8'hA0 + i);
      out_ready = 1'b1;
      valid = 16'h0008; cycle();
      valid = 16'h0011;
      for (int t = 0; t < 4; t++) cycle();
      rand_phase(60, 5);

      valid = 16'h0000; out_ready = 1'b1;
      cycle(); cycle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data bits per channel.
REQ-002 The block SHALL have parameter N_INS, default 8, meaning input channel count (2..16, need not be a power of two).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_aL, input, 1, meaning reset, asynchronous, active-low.
REQ-005 The block SHALL have port ins, input, N_INS x WIDTH, meaning per-channel data.
REQ-006 The block SHALL have port ins_valid, input, N_INS, meaning per-channel request.
REQ-007 The block SHALL have port ins_ready, output, N_INS, meaning per-channel accept (one-hot or zero).
REQ-008 The block SHALL have port out, output, WIDTH, meaning registered selected data.
REQ-009 The block SHALL have port out_sel, output, clog2(N_INS), meaning index of the channel that supplied out.
REQ-010 The block SHALL have port out_valid, output, 1, meaning out/out_sel hold a beat.
REQ-011 The block SHALL have port out_ready, input, 1, meaning consumer accepts the beat.

Function
REQ-012 Transfer on a channel SHALL occur in a cycle where ins_valid[i] and ins_ready[i] are both 1; transfer on the output SHALL occur where out_valid and out_ready are both 1.
REQ-013 The output stage SHALL be a single register; can_load = !out_valid | out_ready (simultaneous drain and load permitted).
REQ-014 Grant SHALL go to the first requesting channel at or after priority pointer ptr, searching upward and wrapping from N_INS-1 to 0.
REQ-015 ins_ready[i] SHALL be 1 only for the granted channel and only when can_load is 1; all other bits 0.
REQ-016 On a channel transfer, out, out_sel and out_valid=1 SHALL load at the next clock edge (latency exactly 1 cycle, full throughput of 1 beat/cycle).
REQ-017 On a channel transfer from channel g, ptr SHALL become g+1, wrapping to 0 when g = N_INS-1; ptr SHALL otherwise hold.
REQ-018 While out_valid=1 and out_ready=0, out and out_sel SHALL remain stable and all ins_ready SHALL be 0.
REQ-019 On output drain with no channel transfer, out_valid SHALL fall to 0 next cycle; out/out_sel values are then don't-care.
REQ-020 With no ins_valid bits set, ins_ready SHALL be all 0 and ptr SHALL hold.
REQ-021 ins_ready SHALL depend combinationally on ins_valid, ptr, out_valid and out_ready only; no path from ins data to any ready.
REQ-022 No requester SHALL wait more than N_INS-1 transfers of other channels before its own grant while it holds ins_valid.

Reset
REQ-023 Assertion of rst_aL low SHALL immediately, independent of clk, clear out_valid to 0, ptr to 0 and out_sel to 0; out data SHALL reset to 0.
REQ-024 Reset asserted mid-stream SHALL discard any held beat; no beat SHALL be presented after deassertion until a new channel transfer.
REQ-025 During reset, ins_ready SHALL be all 0.

Structure
REQ-026 The clog2-based select width and the grant-index type SHALL live in the shared core package, reused by other arbiters.
REQ-027 The round-robin search SHALL be a separate combinational sub-module rr_prio_enc (inputs request vector and ptr; outputs one-hot grant and index).
REQ-028 The data selection SHALL be an AND-OR structure driven by the one-hot grant, not a priority chain.

Verification (N_INS=4, WIDTH=8 unless stated)
REQ-029 Reset then ins_valid=4'b1111, out_ready=1, ins={8'h33,8'h22,8'h11,8'h00} held -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out 00,11,22,33,00.
REQ-030 ptr=2 after a grant to channel 1, ins_valid=4'b0011 -> grant channel 0 (wrap), next ptr=1.
REQ-031 out_valid=1, out_ready=0 for 5 cycles with all ins_valid=1 -> out/out_sel unchanged, ins_ready=0 every cycle; on out_ready=1 new beat loads same cycle edge.
REQ-032 Single requester channel 3 continuously valid, out_ready=1 -> grant every cycle, out_valid stays 1, ptr wraps 0.
REQ-033 N_INS=5: requests on 4 and 0 only, ptr=4 -> grants 4 then 0 then 4; out_sel never exceeds 4.
REQ-034 rst_aL asserted low between clock edges while out_valid=1 -> out_valid=0 before next edge; after release with ins_valid=0, out_valid stays 0.
